// File: rtl/uop_split_queue_pkg.sv
// Shared types for the decode-side uop splitter: operation/exception encodings,
// the queued uop record and the HI/LO split classification.
package uop_split_queue_pkg;

  typedef logic [31:0] virt_t;
  typedef logic [31:0] uint32_t;

  typedef enum logic [4:0] {
    OP_ADDU, OP_ADDIU, OP_SUBU, OP_AND, OP_OR, OP_LW, OP_SW, OP_BEQ,
    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU,
    OP_MUL, OP_MFHI, OP_MFLO
  } operation_t;

  typedef struct packed {
    logic       ex;
    logic [4:0] cause;
    virt_t      tval;
  } exception_t;

  typedef struct packed {
    virt_t      pc;
    operation_t op;
    uint32_t    inst;
    exception_t exception;
    logic       is_inst2;
  } uop_t;

  function automatic logic is_split_op(operation_t op);
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MADDU,
      OP_MSUB, OP_MSUBU, OP_MUL: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

  // First half of a pair: its partner is guaranteed to be the next queue entry.
  function automatic logic is_pair_head(uop_t u);
    return is_split_op(u.op) & ~u.exception.ex & ~u.is_inst2;
  endfunction

endpackage

// File: rtl/uop_split_queue_if.sv
// Fetch-group input and decode-group output bundle of the uop split queue.
interface uop_split_queue_if #(
  parameter int IN_WIDTH  = 2,
  parameter int OUT_WIDTH = 2
);
  import uop_split_queue_pkg::*;

  logic                                flush;
  logic       [IN_WIDTH-1:0]           in_valid;
  virt_t      [IN_WIDTH-1:0]           in_pc;
  operation_t [IN_WIDTH-1:0]           in_op;
  uint32_t    [IN_WIDTH-1:0]           in_inst;
  exception_t [IN_WIDTH-1:0]           in_exception;
  logic                                in_ready;
  logic       [OUT_WIDTH-1:0]          out_valid;
  virt_t      [OUT_WIDTH-1:0]          out_pc;
  operation_t [OUT_WIDTH-1:0]          out_op;
  uint32_t    [OUT_WIDTH-1:0]          out_inst;
  exception_t [OUT_WIDTH-1:0]          out_exception;
  logic       [OUT_WIDTH-1:0]          out_is_inst2;
  logic                                out_ready;

  modport master (
    output flush, in_valid, in_pc, in_op, in_inst, in_exception, out_ready,
    input  in_ready, out_valid, out_pc, out_op, out_inst, out_exception, out_is_inst2
  );

  modport slave (
    input  flush, in_valid, in_pc, in_op, in_inst, in_exception, out_ready,
    output in_ready, out_valid, out_pc, out_op, out_inst, out_exception, out_is_inst2
  );

endinterface

// File: rtl/uop_split_queue_queue.sv
// Circular uop storage: up to WR_W compacted writes at tail and RD_W entries
// exposed from head per cycle; flush empties the queue and wins over push/pop.
module uop_queue
  import uop_split_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WR_W  = 4,
  parameter int RD_W  = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [PTR_W:0]     wr_cnt,
  input  uop_t [WR_W-1:0]    wr_data,
  input  logic [PTR_W:0]     rd_cnt,
  output uop_t [RD_W-1:0]    rd_data,
  output logic [PTR_W:0]     count
);

  uop_t              mem [DEPTH];
  logic [PTR_W-1:0]  head, tail;
  logic [WR_W-1:0]   wr_en;
  logic [PTR_W-1:0]  wr_idx [WR_W];

  for (genvar i = 0; i < WR_W; i++) begin : g_wr
    assign wr_en[i]  = wr_cnt > (PTR_W+1)'(i);
    assign wr_idx[i] = tail + PTR_W'(i);
  end

  for (genvar j = 0; j < RD_W; j++) begin : g_rd
    assign rd_data[j] = mem[head + PTR_W'(j)];
  end

  // Pointer width equals log2(DEPTH), so plain addition wraps modulo DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + rd_cnt[PTR_W-1:0];
      tail  <= tail + wr_cnt[PTR_W-1:0];
      count <= count + wr_cnt - rd_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (!flush) begin
      for (int i = 0; i < WR_W; i++)
        if (wr_en[i]) mem[wr_idx[i]] <= wr_data[i];
    end
  end

endmodule

// File: rtl/uop_split_queue.sv
// Decode-side micro-op splitter: expands HI/LO-pair ops into two uops, queues them
// and forms pair-aligned issue groups. Define UOP_SPLIT_PERF_EN for perf counters.
module uop_split_queue
  import uop_split_queue_pkg::*;
#(
  parameter int IN_WIDTH    = 2,
  parameter int OUT_WIDTH   = 2,
  parameter int QUEUE_DEPTH = 8,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  uop_split_queue_if.slave       bus
`ifdef UOP_SPLIT_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0]   perf_split_cnt,
  output logic [CNT_WIDTH-1:0]   perf_stall_cnt
`endif
);

  localparam int WR_W   = 2 * IN_WIDTH;
  localparam int PTR_W  = $clog2(QUEUE_DEPTH);
  localparam int WIDX_W = $clog2(WR_W);
  localparam logic [PTR_W:0] ONE = (PTR_W+1)'(1);

  logic [IN_WIDTH-1:0]   lane_split;
  uop_t [WR_W-1:0]       wr_data;
  uop_t [OUT_WIDTH-1:0]  rd_data;
  logic [PTR_W:0]        wr_total, wr_cnt, rd_cnt, n_out, q_count;
  logic [OUT_WIDTH-1:0]  out_v;
  logic                  in_ready;
  logic                  brk;
  uop_t                  u;

  for (genvar i = 0; i < IN_WIDTH; i++) begin : g_lane
    assign lane_split[i] = bus.in_valid[i] & is_split_op(bus.in_op[i]) & ~bus.in_exception[i].ex;
  end

  // Compact valid slots in program order; a split inst occupies two adjacent entries.
  always_comb begin
    wr_data  = '0;
    wr_total = '0;
    u        = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (bus.in_valid[i]) begin
        u.pc        = bus.in_pc[i];
        u.op        = bus.in_op[i];
        u.inst      = bus.in_inst[i];
        u.exception = bus.in_exception[i];
        u.is_inst2  = 1'b0;
        wr_data[wr_total[WIDX_W-1:0]] = u;
        wr_total = wr_total + ONE;
        if (lane_split[i]) begin
          u.is_inst2 = 1'b1;
          wr_data[wr_total[WIDX_W-1:0]] = u;
          wr_total = wr_total + ONE;
        end
      end
    end
  end

  // Registered count only: acceptance never depends on this cycle's pop.
  assign in_ready = int'(q_count) <= QUEUE_DEPTH - WR_W;
  assign wr_cnt   = in_ready ? wr_total : '0;

  // A pair head may only sit in an even slot so its partner shares the group.
  always_comb begin
    out_v = '0;
    brk   = 1'b0;
    n_out = '0;
    for (int s = 0; s < OUT_WIDTH; s++) begin
      if (!brk && s < int'(q_count) && !(is_pair_head(rd_data[s]) && s[0])) begin
        out_v[s] = 1'b1;
        n_out    = n_out + ONE;
      end else begin
        brk = 1'b1;
      end
    end
  end

  assign rd_cnt = bus.out_ready ? n_out : '0;

  uop_queue #(
    .DEPTH (QUEUE_DEPTH),
    .WR_W  (WR_W),
    .RD_W  (OUT_WIDTH)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .flush   (bus.flush),
    .wr_cnt  (wr_cnt),
    .wr_data (wr_data),
    .rd_cnt  (rd_cnt),
    .rd_data (rd_data),
    .count   (q_count)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_v;

  for (genvar s = 0; s < OUT_WIDTH; s++) begin : g_out
    assign bus.out_pc[s]        = rd_data[s].pc;
    assign bus.out_op[s]        = rd_data[s].op;
    assign bus.out_inst[s]      = rd_data[s].inst;
    assign bus.out_exception[s] = rd_data[s].exception;
    assign bus.out_is_inst2[s]  = rd_data[s].is_inst2;
  end

`ifdef UOP_SPLIT_PERF_EN
  logic [PTR_W:0]     n_split;
  logic [CNT_WIDTH:0] split_sum, stall_sum;

  always_comb begin
    n_split = '0;
    for (int i = 0; i < IN_WIDTH; i++)
      n_split = n_split + (PTR_W+1)'(lane_split[i]);
    split_sum = {1'b0, perf_split_cnt} +
                ((in_ready && !bus.flush) ? (CNT_WIDTH+1)'(n_split) : '0);
    stall_sum = {1'b0, perf_stall_cnt} + (CNT_WIDTH+1)'(|bus.in_valid && !in_ready);
  end

  // Saturating counters; flush deliberately leaves them alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_split_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      perf_split_cnt <= split_sum[CNT_WIDTH] ? '1 : split_sum[CNT_WIDTH-1:0];
      perf_stall_cnt <= stall_sum[CNT_WIDTH] ? '1 : stall_sum[CNT_WIDTH-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_uop_split_queue.sv
// Randomized scoreboard bench for uop_split_queue with a queue-level reference model.
`timescale 1ns/1ps
module tb_uop_split_queue;
  import uop_split_queue_pkg::*;

  localparam int IW = 2, OW = 2, DEPTH = 8, CW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uop_split_queue_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();
`ifdef UOP_SPLIT_PERF_EN
  logic [CW-1:0] perf_split_cnt, perf_stall_cnt;
`endif

  uop_split_queue #(
    .IN_WIDTH(IW), .OUT_WIDTH(OW), .QUEUE_DEPTH(DEPTH), .CNT_WIDTH(CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef UOP_SPLIT_PERF_EN
    ,
    .perf_split_cnt (perf_split_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  typedef struct {
    virt_t pc; operation_t op; uint32_t inst; exception_t exc; bit is2; bit head;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        pend_q[$];
  int          n_chk = 0, n_fail = 0;
  longint      m_split = 0, m_stall = 0;
  logic [31:0] pc_next = 32'h8000_0000;
  operation_t  op_tab[8] = '{OP_ADDU, OP_MULT, OP_LW, OP_DIVU, OP_MADD, OP_SW, OP_MUL, OP_MSUBU};

  function automatic bit ref_splits(operation_t op, exception_t e);
    return !e.ex && (op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD,
                                OP_MADDU, OP_MSUB, OP_MSUBU, OP_MUL});
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One input cycle; the model decides acceptance from its own occupancy.
  task automatic cycle(input logic [IW-1:0] v, input operation_t o0, input operation_t o1,
                       input bit e0, input bit e1, input bit fl, input bit rdy);
    operation_t ops[IW];
    bit         exs[IW];
    bit         acc;
    exp_t       e;
    ops[0] = o0; ops[1] = o1; exs[0] = e0; exs[1] = e1;
    acc = (DEPTH - exp_q.size()) >= 2 * IW;
    bus.flush     = fl;
    bus.out_ready = rdy;
    bus.in_valid  = v;
    for (int i = 0; i < IW; i++) begin
      bus.in_pc[i]   = pc_next;
      pc_next        = pc_next + 32'd4;
      bus.in_op[i]   = ops[i];
      bus.in_inst[i] = $urandom;
      bus.in_exception[i] = exs[i] ? '{ex: 1'b1, cause: 5'($urandom), tval: $urandom} : '0;
    end
    if (!rst) begin
      if (|v && !acc) m_stall++;
      if (acc && !fl) begin
        for (int i = 0; i < IW; i++) begin
          if (v[i]) begin
            e.pc = bus.in_pc[i]; e.op = ops[i]; e.inst = bus.in_inst[i];
            e.exc = bus.in_exception[i]; e.is2 = 1'b0;
            e.head = ref_splits(ops[i], e.exc);
            pend_q.push_back(e);
            if (e.head) begin
              m_split++;
              e.is2 = 1'b1; e.head = 1'b0;
              pend_q.push_back(e);
            end
          end
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input bit rdy);
    cycle('0, OP_ADDU, OP_ADDU, 1'b0, 1'b0, 1'b0, rdy);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 20) begin idle(1'b1); k++; end
    idle(1'b1);
    check("drain_empty", 64'(bus.out_valid), 64'd0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    idle(1'b0);
    idle(1'b0);
    rst = 1'b0;
    m_split = 0;
    m_stall = 0;
  endtask

  // Monitor: compare DUT group with the model's expected group, then advance the model.
  int              mon_n;
  logic [OW-1:0]   mon_ev;
  always @(negedge clk) begin
    if (rst) begin
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      exp_q.delete();
      pend_q.delete();
    end else begin
      check("in_ready", 64'(bus.in_ready), 64'((DEPTH - exp_q.size()) >= 2 * IW));
      mon_n = 0;
      while (mon_n < OW && mon_n < exp_q.size()) begin
        if (exp_q[mon_n].head && mon_n[0]) break;
        mon_n++;
      end
      mon_ev = '0;
      for (int s = 0; s < mon_n; s++) mon_ev[s] = 1'b1;
      check("out_valid", 64'(bus.out_valid), 64'(mon_ev));
      for (int s = 0; s < mon_n; s++) begin
        check($sformatf("pc[%0d]", s), 64'(bus.out_pc[s]), 64'(exp_q[s].pc));
        check($sformatf("op[%0d]", s), 64'(bus.out_op[s]), 64'(exp_q[s].op));
        check($sformatf("inst[%0d]", s), 64'(bus.out_inst[s]), 64'(exp_q[s].inst));
        check($sformatf("exc[%0d]", s), 64'(bus.out_exception[s]), 64'(exp_q[s].exc));
        check($sformatf("is_inst2[%0d]", s), 64'(bus.out_is_inst2[s]), 64'(exp_q[s].is2));
      end
      if (bus.flush) begin
        exp_q.delete();
        pend_q.delete();
      end else begin
        if (bus.out_ready) repeat (mon_n) void'(exp_q.pop_front());
        while (pend_q.size() != 0) exp_q.push_back(pend_q.pop_front());
      end
    end
  end

  initial begin
    bus.flush = 1'b0; bus.out_ready = 1'b0; bus.in_valid = '0;
    bus.in_pc = '0; bus.in_op = '{default: OP_ADDU}; bus.in_inst = '0; bus.in_exception = '0;
    @(posedge clk); #1;
    pulse_reset();
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_in_ready", 64'(bus.in_ready), 64'd1);

    // ADDU + MULT: the pair head cannot take odd slot 1, so only ADDU issues first.
    cycle(2'b11, OP_ADDU, OP_MULT, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t1_valid_first", 64'(bus.out_valid), 64'b01);
    idle(1'b1);
    check("t1_valid_pair", 64'(bus.out_valid), 64'b11);
    check("t1_is_inst2", 64'(bus.out_is_inst2), 64'b10);
    drain();

    // Excepting MADD stays a single uop.
    cycle(2'b01, OP_MADD, OP_ADDU, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t2_valid", 64'(bus.out_valid), 64'b01);
    check("t2_ex", 64'(bus.out_exception[0].ex), 64'd1);
    drain();

    // Back-pressure thresholds.
    cycle(2'b11, OP_MULT, OP_MULT, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t3_ready_cnt4", 64'(bus.in_ready), 64'd1);
    cycle(2'b11, OP_MULT, OP_MULT, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t3_ready_cnt8", 64'(bus.in_ready), 64'd0);
    idle(1'b1);
    check("t3_ready_cnt6", 64'(bus.in_ready), 64'd0);
    idle(1'b1);
    check("t3_ready_cnt4b", 64'(bus.in_ready), 64'd1);
    drain();

    // 20 ADDU streamed across pointer wrap.
    pc_next = 32'h8000_0000;
    repeat (10) cycle(2'b11, OP_ADDU, OP_ADDU, 1'b0, 1'b0, 1'b0, 1'b1);
    drain();

    // Flush with 5 queued uops and a concurrent push/pop.
    cycle(2'b11, OP_ADDU, OP_ADDU, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(2'b11, OP_MULT, OP_ADDU, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(2'b11, OP_ADDU, OP_ADDU, 1'b0, 1'b0, 1'b1, 1'b1);
    check("t5_out_valid", 64'(bus.out_valid), 64'd0);
    check("t5_in_ready", 64'(bus.in_ready), 64'd1);
    idle(1'b1);

    for (int c = 0; c < 250; c++)
      cycle(2'($urandom), op_tab[$urandom_range(0, 7)], op_tab[$urandom_range(0, 7)],
            $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0);

    // Mid-run reset, then 3 accepted splits and 2 stalled cycles.
    cycle(2'b11, OP_MULT, OP_MUL, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse_reset();
    cycle(2'b11, OP_MULT, OP_MULT, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(2'b01, OP_MULT, OP_ADDU, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(2'b11, OP_ADDU, OP_ADDU, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(2'b10, OP_ADDU, OP_ADDU, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef UOP_SPLIT_PERF_EN
    check("t6_split_cnt", 64'(perf_split_cnt), 64'd3);
    check("t6_stall_cnt", 64'(perf_stall_cnt), 64'd2);
`endif
    drain();

    for (int c = 0; c < 250; c++)
      cycle(2'($urandom), op_tab[$urandom_range(0, 7)], op_tab[$urandom_range(0, 7)],
            $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0);
    drain();
`ifdef UOP_SPLIT_PERF_EN
    check("perf_split_model", 64'(perf_split_cnt), 64'(m_split));
    check("perf_stall_model", 64'(perf_stall_cnt), 64'(m_stall));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
